// File: rtl/prn_free_arbiter.sv
// ============================================================================
// Module   : prn_free_arbiter
// Brief    : Round-robin collector of freed PRN groups into a circular buffer
//            that drains up to NUM_LANES PRNs per cycle into the renamer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prn_free_arbiter #(
    parameter int PRN_BITS  = 6,
    parameter int NUM_LANES = 3,
    parameter int NUM_SRC   = 2,
    parameter int BUF_DEPTH = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_SRC-1:0]                            i_src_valid,
    input  logic [NUM_SRC-1:0][NUM_LANES-1:0]             i_src_prn_valid,
    input  logic [NUM_SRC-1:0][NUM_LANES-1:0][PRN_BITS-1:0] i_src_prns,
    output logic [NUM_SRC-1:0]                            o_src_ready,
    output logic [NUM_LANES-1:0]                          o_free_valid,
    output logic [NUM_LANES-1:0][PRN_BITS-1:0]            o_free_prns,
    output logic [$clog2(BUF_DEPTH+1)-1:0]                o_count,
    output logic                                          o_busy
);

    localparam int c_PTR_BITS = $clog2(BUF_DEPTH);
    localparam int c_CNT_BITS = $clog2(BUF_DEPTH+1);
    localparam int c_RR_BITS  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [PRN_BITS-1:0]   c_INVALID   = {PRN_BITS{1'b1}};
    localparam logic [c_CNT_BITS-1:0] c_SPACE_MAX = c_CNT_BITS'(BUF_DEPTH - NUM_LANES);
    localparam logic [c_CNT_BITS-1:0] c_LANES     = c_CNT_BITS'(NUM_LANES);

    logic [PRN_BITS-1:0]   r_buf [BUF_DEPTH];
    logic [c_PTR_BITS-1:0] r_head;
    logic [c_PTR_BITS-1:0] r_tail;
    logic [c_CNT_BITS-1:0] r_count;
    logic [c_RR_BITS-1:0]  r_rr;

    logic                  w_found;
    logic [c_RR_BITS-1:0]  w_winner;
    logic                  w_space;
    logic                  w_accept;
    logic [c_RR_BITS-1:0]  w_rr_next;
    logic [NUM_LANES-1:0]  w_lane_push;
    logic [c_PTR_BITS-1:0] w_waddr [NUM_LANES];
    logic [c_CNT_BITS-1:0] w_push;
    logic [c_CNT_BITS-1:0] w_pop;

    // Space is judged on the pre-pop count, so a full group always fits.
    assign w_space  = (r_count <= c_SPACE_MAX);
    assign w_accept = w_found && w_space;
    assign w_pop    = (r_count < c_LANES) ? r_count : c_LANES;

    always_comb begin : p_arb
        logic [c_RR_BITS-1:0] w_cand;
        w_found   = 1'b0;
        w_winner  = '0;
        w_cand    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_cand = c_RR_BITS'((int'(r_rr) + k) % NUM_SRC);
            if (!w_found && i_src_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
        w_rr_next   = c_RR_BITS'((int'(w_winner) + 1) % NUM_SRC);
        o_src_ready = '0;
        if (w_found) begin
            o_src_ready[w_winner] = w_space;
        end
    end

    // Valid lanes are packed densely in lane order starting at tail.
    always_comb begin : p_pack
        w_push = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            w_lane_push[j] = w_accept && i_src_prn_valid[w_winner][j] &&
                             (i_src_prns[w_winner][j] != c_INVALID);
            w_waddr[j]     = r_tail + c_PTR_BITS'(w_push);
            if (w_lane_push[j]) begin
                w_push = w_push + c_CNT_BITS'(1);
            end
        end
    end

    always_comb begin : p_drain
        for (int i = 0; i < NUM_LANES; i++) begin
            o_free_valid[i] = (c_CNT_BITS'(i) < r_count);
            o_free_prns[i]  = r_buf[r_head + c_PTR_BITS'(i)];
        end
    end

    assign o_count = r_count;
    assign o_busy  = (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_rr    <= '0;
            for (int b = 0; b < BUF_DEPTH; b++) begin
                r_buf[b] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_LANES; j++) begin
                if (w_lane_push[j]) begin
                    r_buf[w_waddr[j]] <= i_src_prns[w_winner][j];
                end
            end
            r_tail  <= r_tail + c_PTR_BITS'(w_push);
            r_head  <= r_head + c_PTR_BITS'(w_pop);
            r_count <= r_count - w_pop + w_push;
            if (w_accept) begin
                r_rr <= w_rr_next;
            end
        end
    end

endmodule

`default_nettype wire
